// File: rtl/rf_read_arbiter_pkg.sv
// Shared types and helpers for the register-file read arbiter.
package rf_arb_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [4:0] ZR_ADDR = 5'd31;

  // Width needed to index n items, never less than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned p;
      p = (32'(ptr) + i) % NREQ;
      if (!any && req[p]) begin
        any = 1'b1;
        idx = ID_W'(p);
      end
    end
    if (any) onehot = NREQ'(1) << idx;
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin sharing of the register-file read mux tree with a fixed settle delay.
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int SETTLE_CYC = 2,
  parameter int ZR_BYPASS  = 1,
  localparam int ID_W      = id_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr,
  output logic [NREQ-1:0]        gnt,
  output logic [ADDR_W-1:0]      rf_rd_addr,
  input  logic [DATA_W-1:0]      rf_rd_data,
  output logic                   rvalid,
  output logic [ID_W-1:0]        rid,
  output logic [DATA_W-1:0]      rdata
);

  localparam int CNT_W = id_w(SETTLE_CYC + 1);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("rf_read_arbiter: SETTLE_CYC must be >= 1");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("rf_read_arbiter: NREQ must be in 2..8");
  end

  state_t              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic [ADDR_W-1:0]   rf_rd_addr_q;
  logic                rvalid_q;
  logic [ID_W-1:0]     rid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                pick_any;
  logic [ID_W-1:0]     pick_idx;
  logic [NREQ-1:0]     pick_onehot;
  logic [ADDR_W-1:0]   win_addr;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                zr_grant;
  logic                zr_capture;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Bypass is decided from the held select lines, so no extra flag is stored.
  always_comb begin
    win_addr   = addr[32'(pick_idx)*ADDR_W +: ADDR_W];
    rr_ptr_d   = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + ID_W'(1);
    zr_grant   = (ZR_BYPASS != 0) && (win_addr == ADDR_W'(ZR_ADDR));
    zr_capture = (ZR_BYPASS != 0) && (rf_rd_addr_q == ADDR_W'(ZR_ADDR));
    cnt_d      = zr_grant ? CNT_W'(1) : CNT_W'(SETTLE_CYC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rf_rd_addr_q <= '0;
      rvalid_q     <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q        <= pick_onehot;
            rf_rd_addr_q <= win_addr;
            rid_q        <= pick_idx;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdata_q  <= zr_capture ? '0 : rf_rd_data;
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rvalid     = rvalid_q;
  assign rid        = rid_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: one SETTLE_CYC=2 instance and one SETTLE_CYC=1 instance.
module tb_rf_read_arbiter;

  logic        clk;
  logic        reset_n;

  logic [3:0]  req;
  logic [19:0] addr;
  logic [3:0]  gnt;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_rd_data;
  logic        rvalid;
  logic [1:0]  rid;
  logic [63:0] rdata;

  logic [3:0]  req1;
  logic [19:0] addr1;
  logic [3:0]  gnt1;
  logic [4:0]  rf_rd_addr1;
  logic [63:0] rf_rd_data1;
  logic        rvalid1;
  logic [1:0]  rid1;
  logic [63:0] rdata1;

  int errors = 0;
  int checks = 0;

  rf_read_arbiter #(
    .NREQ(4), .DATA_W(64), .ADDR_W(5), .SETTLE_CYC(2), .ZR_BYPASS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rvalid(rvalid),
    .rid(rid), .rdata(rdata)
  );

  rf_read_arbiter #(
    .NREQ(4), .DATA_W(64), .ADDR_W(5), .SETTLE_CYC(1), .ZR_BYPASS(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .addr(addr1), .gnt(gnt1),
    .rf_rd_addr(rf_rd_addr1), .rf_rd_data(rf_rd_data1), .rvalid(rvalid1),
    .rid(rid1), .rdata(rdata1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [3:0] exp_g;

    reset_n     = 1'b0;
    req         = '0;
    addr        = '0;
    rf_rd_data  = '0;
    req1        = '0;
    addr1       = '0;
    rf_rd_data1 = '0;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    tick();
    reset_n = 1'b1;

    // Single request from requester 1.
    addr[1*5 +: 5] = 5'd5;
    rf_rd_data     = 64'hDEAD_BEEF_0000_0005;
    req            = 4'b0010;
    tick();
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_addr", rf_rd_addr, 5);
    chk("t1_rvalid_k", rvalid, 0);
    req = '0;
    tick();
    chk("t1_gnt_k1", gnt, 0);
    chk("t1_rvalid_k1", rvalid, 0);
    chk("t1_addr_hold", rf_rd_addr, 5);
    tick();
    chk("t1_rvalid_k2", rvalid, 1);
    chk("t1_rid", rid, 1);
    chk("t1_rdata", rdata, 64'hDEAD_BEEF_0000_0005);
    tick();
    chk("t1_rvalid_k3", rvalid, 0);
    chk("t1_rdata_hold", rdata, 64'hDEAD_BEEF_0000_0005);

    // Round robin with all requesters held; reset first so the pointer starts at 0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(10 + i);
    rf_rd_data = 64'h0123_4567_89AB_CDEF;
    req        = 4'b1111;
    for (int t = 0; t < 15; t++) begin
      tick();
      w     = (t / 3) % 4;
      exp_g = (t % 3 == 0) ? 4'(1 << w) : 4'b0000;
      chk("rr_gnt", gnt, exp_g);
      chk("rr_rvalid", rvalid, (t % 3 == 2) ? 1 : 0);
      if (t % 3 == 0) chk("rr_addr", rf_rd_addr, 10 + w);
      if (t % 3 == 2) begin
        chk("rr_rid", rid, w);
        chk("rr_rdata", rdata, 64'h0123_4567_89AB_CDEF);
      end
    end
    req = '0;
    tick();
    chk("rr_idle_gnt", gnt, 0);

    // XZR bypass: rr_ptr is 1 here, only requester 2 asks.
    addr[2*5 +: 5] = 5'd31;
    rf_rd_data     = '1;
    req            = 4'b0100;
    tick();
    chk("zr_gnt", gnt, 4'b0100);
    chk("zr_addr", rf_rd_addr, 31);
    req = '0;
    tick();
    chk("zr_rvalid", rvalid, 1);
    chk("zr_rdata", rdata, 0);
    chk("zr_rid", rid, 2);
    tick();
    chk("zr_rvalid_off", rvalid, 0);

    // Withdrawal: rr_ptr is 3; requester 1 occupies the port, 3 pulses and leaves.
    addr[1*5 +: 5] = 5'd6;
    addr[0*5 +: 5] = 5'd7;
    addr[3*5 +: 5] = 5'd8;
    rf_rd_data     = 64'h0000_0000_0000_00A5;
    req            = 4'b0010;
    tick();
    chk("wd_gnt1", gnt, 4'b0010);
    req = 4'b1001;
    tick();
    chk("wd_wait_gnt", gnt, 0);
    req = 4'b0001;
    tick();
    chk("wd_rvalid1", rvalid, 1);
    chk("wd_rid1", rid, 1);
    chk("wd_cap_gnt", gnt, 0);
    tick();
    chk("wd_gnt0", gnt, 4'b0001);
    chk("wd_addr0", rf_rd_addr, 7);
    req = '0;
    tick();
    tick();
    chk("wd_rvalid0", rvalid, 1);
    chk("wd_rid0", rid, 0);
    chk("wd_rdata0", rdata, 64'h0000_0000_0000_00A5);

    // Reset one cycle after a grant aborts the read.
    addr[2*5 +: 5] = 5'd9;
    req            = 4'b0100;
    tick();
    chk("mr_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("mr_addr_pre", rf_rd_addr, 9);
    reset_n = 1'b0;
    #1;
    chk("mr_async_addr", rf_rd_addr, 0);
    chk("mr_async_rid", rid, 0);
    chk("mr_async_rdata", rdata, 0);
    chk("mr_async_rvalid", rvalid, 0);
    chk("mr_async_gnt", gnt, 0);
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("mr_no_rvalid", rvalid, 0);
    end
    req = 4'b1111;
    tick();
    chk("mr_first_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    tick();
    chk("mr_rvalid", rvalid, 1);

    // Back-to-back on the SETTLE_CYC=1 instance, requester 1 held throughout.
    addr1[1*5 +: 5] = 5'd4;
    rf_rd_data1     = 64'h0000_0000_0000_0077;
    req1            = 4'b0010;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("bb_gnt", gnt1, (t % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("bb_rvalid", rvalid1, (t % 2 == 1) ? 1 : 0);
      if (t % 2 == 1) begin
        chk("bb_rid", rid1, 1);
        chk("bb_rdata", rdata1, 64'h0000_0000_0000_0077);
      end
    end
    req1 = '0;
    tick();
    chk("bb_end_gnt", gnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
